// File: rtl/tinyalu_gen2.sv
// Small multi-cycle ALU: one operation in flight at a time, with fixed latency 1
// for every opcode except multiply, which takes MULT_LAT clocks.
module tinyalu_gen2 #(
    parameter int WIDTH    = 8,
    parameter int MULT_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(MULT_LAT + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t               state_reg;
    logic [CW-1:0]        cnt_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2:0]           op_reg;

    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   b_ext;
    logic [2*WIDTH-1:0]   calc;
    logic                 writes_result;
    logic                 illegal;

    // The datapath works only from the latched operands, so input changes
    // during EXEC cannot disturb the result committed at the final edge.
    always_comb begin
        a_ext         = {{WIDTH{1'b0}}, a_reg};
        b_ext         = {{WIDTH{1'b0}}, b_reg};
        calc          = '0;
        writes_result = 1'b1;
        illegal       = 1'b0;
        case (op_reg)
            OP_ADD:  calc = a_ext + b_ext;
            OP_AND:  calc = a_ext & b_ext;
            OP_XOR:  calc = a_ext ^ b_ext;
            OP_MUL:  calc = a_ext * b_ext;
            OP_SUB:  calc = a_ext - b_ext;
            OP_NOP:  writes_result = 1'b0;
            default: begin
                writes_result = 1'b0;
                illegal       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        op_reg    <= op;
                        cnt_reg   <= (op == OP_MUL) ? MUL_LOAD : '0;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        done      <= 1'b1;
                        err       <= illegal;
                        if (writes_result) begin
                            result <= calc;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg == EXEC);

endmodule

// File: tb/tb_tinyalu_gen2.sv
// Bench for tinyalu_gen2: directed corner cases then random traffic, every cycle
// compared against a transaction-level model (accept edge + latency -> completion).
module tb_tinyalu_gen2;

    localparam int WIDTH    = 8;
    localparam int MULT_LAT = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic [2:0]       op_in = '0;
    logic             start_in = 1'b0;
    logic             busy;
    logic             done;
    logic             err;
    logic [2*WIDTH-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    tinyalu_gen2 #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .A      (a_in),
        .B      (b_in),
        .op     (op_in),
        .start  (start_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    always #5 clk = ~clk;

    // Transaction model: an accepted op finishes at accept_edge + latency.
    longint      edge_n = 0;
    longint      fin_edge = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    logic [15:0] m_res = '0;
    logic [15:0] m_pend = '0;
    logic [2:0]  m_op = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_calc(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned r = 0;
        case (o)
            3'd1: r = x + y;
            3'd2: r = x & y;
            3'd3: r = x ^ y;
            3'd4: r = x * y;
            3'd5: r = x - y;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_done = 0;
        m_err  = 0;
        m_res  = '0;
    endtask

    task automatic check_outputs(input string why);
        check({why, "_busy"},   busy,   m_busy);
        check({why, "_done"},   done,   m_done);
        check({why, "_err"},    err,    m_err);
        check({why, "_result"}, result, m_res);
    endtask

    // One clock: model advances on the edge with the inputs the DUT saw,
    // then outputs are compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        edge_n++;
        if (reset_n) begin
            m_done = 0;
            m_err  = 0;
            if (m_busy && edge_n == fin_edge) begin
                m_busy = 0;
                m_done = 1;
                m_err  = (m_op >= 3'd6);
                if (m_op >= 3'd1 && m_op <= 3'd5) m_res = m_pend;
            end else if (!m_busy && start_in) begin
                m_busy   = 1;
                fin_edge = edge_n + ((op_in == 3'd4) ? MULT_LAT : 1);
                m_pend   = ref_calc(a_in, b_in, op_in);
                m_op     = op_in;
            end
        end
        #1;
        check_outputs("cyc");
    endtask

    task automatic hit_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o, output int bc);
        int w = 0;
        a_in = a; b_in = b; op_in = o; start_in = 1'b1;
        cycle();
        start_in = 1'b0;
        bc = busy ? 1 : 0;
        while (!done && w < 20) begin
            a_in = $urandom; b_in = $urandom; op_in = $urandom;
            cycle();
            if (busy) bc++;
            w++;
        end
        check("op_timeout", done, 1);
    endtask

    initial begin
        int bc;
        int dn;

        #1 reset_n = 1'b0;
        model_reset();
        repeat (2) cycle();
        reset_n = 1'b1;

        // First start right after release is accepted on the first edge.
        run_op(8'hFF, 8'hFF, 3'd1, bc);
        check("add_res", result, 16'h01FE);
        check("add_busy_len", bc, 1);
        check("add_err", err, 0);

        run_op(8'hFF, 8'hFF, 3'd4, bc);
        check("mul_res", result, 16'hFE01);
        check("mul_busy_len", bc, MULT_LAT);

        run_op(8'd3, 8'd5, 3'd5, bc);
        check("sub_res", result, 16'hFFFE);
        run_op(8'hF0, 8'h3C, 3'd3, bc);
        check("xor_res", result, 16'h00CC);
        run_op(8'hF0, 8'h3C, 3'd2, bc);
        check("and_res", result, 16'h0030);

        run_op(8'h12, 8'h34, 3'd7, bc);
        check("ill_err", err, 1);
        check("ill_res", result, 16'h0030);
        check("ill_busy_len", bc, 1);
        run_op(8'h56, 8'h78, 3'd0, bc);
        check("nop_err", err, 0);
        check("nop_res", result, 16'h0030);

        // Start held high with mul: one completion every MULT_LAT+1 cycles.
        a_in = 8'hFF; b_in = 8'hFF; op_in = 3'd4; start_in = 1'b1;
        dn = 0;
        repeat (16) begin
            cycle();
            if (done) dn++;
        end
        start_in = 1'b0;
        check("tput_dones", dn, 4);
        repeat (5) cycle();

        // A second pulse while busy is dropped.
        dn = 0;
        a_in = 8'd7; b_in = 8'd9; op_in = 3'd4; start_in = 1'b1;
        cycle(); if (done) dn++;
        start_in = 1'b0;
        cycle(); if (done) dn++;
        start_in = 1'b1;
        cycle(); if (done) dn++;
        start_in = 1'b0;
        repeat (8) begin cycle(); if (done) dn++; end
        check("pulse_dones", dn, 1);
        check("pulse_res", result, 16'd63);

        // Reset in the middle of a multiply aborts it.
        a_in = 8'hAA; b_in = 8'h55; op_in = 3'd4; start_in = 1'b1;
        cycle();
        start_in = 1'b0;
        cycle();
        hit_reset();
        repeat (2) cycle();
        reset_n = 1'b1;
        dn = 0;
        repeat (6) begin cycle(); if (done) dn++; end
        check("rst_no_done", dn, 0);

        // Random traffic with occasional asynchronous resets.
        repeat (3000) begin
            start_in = ($urandom_range(0, 2) != 0);
            a_in     = $urandom;
            b_in     = $urandom;
            op_in    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                hit_reset();
                cycle();
                reset_n = 1'b1;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
